// File: rtl/imm_gen_skid_if.sv
// rtl/imm_gen_skid_if.sv - Decode-to-execute handshake bundle for the immediate generator
interface imm_gen_skid_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic [2:0]       ImmFormatD;
   logic [24:0]      InstrD;
   logic [TAG_W-1:0] TagD;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  ExtImmE;
   logic [TAG_W-1:0] TagE;
   logic             fmt_err;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  ImmFormatD, InstrD, TagD, in_valid, out_ready,
      output in_ready, ExtImmE, TagE, fmt_err, out_valid
   );

   modport master (
      output ImmFormatD, InstrD, TagD, in_valid, out_ready,
      input  in_ready, ExtImmE, TagE, fmt_err, out_valid
   );
endinterface

// File: rtl/imm_gen_skid.sv
// rtl/imm_gen_skid.sv - Registered immediate generator behind a 2-entry skid FIFO
module imm_gen_skid #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   imm_gen_skid_if.slave s
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [XLEN-1:0]  r_e0_imm;
   logic [XLEN-1:0]  r_e1_imm;
   logic [TAG_W-1:0] r_e0_tag;
   logic [TAG_W-1:0] r_e1_tag;
   logic             r_e0_err;
   logic             r_e1_err;
   logic [XLEN-1:0]  w_imm;
   logic             w_err;
   logic [31:7]      w_instr;
   logic             w_push;
   logic             w_pop;
   logic             w_ld_e0_in;
   logic             w_ld_e0_e1;
   logic             w_ld_e1_in;

   // Port bit 0 is instruction bit 7, so index in instruction coordinates
   assign w_instr = s.InstrD;

   always_comb begin
      w_imm = '0;
      w_err = 1'b0;
      case (s.ImmFormatD)
         3'b000: w_imm = XLEN'($signed(w_instr[31:20]));
         3'b001: w_imm = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
         3'b010: w_imm = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                        w_instr[11:8], 1'b0}));
         3'b011: w_imm = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                        w_instr[30:21], 1'b0}));
         3'b100: w_imm = XLEN'($signed({w_instr[31:12], 12'b0}));
         3'b101: w_imm = XLEN'(w_instr[19:15]);
         3'b110: begin
            if (XLEN == 32) w_imm = XLEN'(w_instr[24:20]);
            else            w_imm = XLEN'(w_instr[25:20]);
         end
         default: begin
            w_imm = '0;
            w_err = 1'b1;
         end
      endcase
   end

   // in_ready comes from registered state only, never from out_ready
   assign s.in_ready  = (r_state != FULL) && !reset;
   assign s.out_valid = (r_state != EMPTY);
   assign s.ExtImmE   = r_e0_imm;
   assign s.TagE      = r_e0_tag;
   assign s.fmt_err   = r_e0_err;

   assign w_push = s.in_valid && s.in_ready && !flush;
   assign w_pop  = s.out_valid && s.out_ready && !flush;

   always_comb begin
      w_state_nxt = r_state;
      w_ld_e0_in  = 1'b0;
      w_ld_e0_e1  = 1'b0;
      w_ld_e1_in  = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_push) begin
               w_state_nxt = ONE;
               w_ld_e0_in  = 1'b1;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               w_ld_e0_in = 1'b1;
            end else if (w_push) begin
               w_state_nxt = FULL;
               w_ld_e1_in  = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_pop) begin
               w_state_nxt = ONE;
               w_ld_e0_e1  = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      if (flush) w_state_nxt = EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e0_imm <= '0;
         r_e0_tag <= '0;
         r_e0_err <= 1'b0;
         r_e1_imm <= '0;
         r_e1_tag <= '0;
         r_e1_err <= 1'b0;
      end else begin
         if (w_ld_e0_in) begin
            r_e0_imm <= w_imm;
            r_e0_tag <= s.TagD;
            r_e0_err <= w_err;
         end else if (w_ld_e0_e1) begin
            r_e0_imm <= r_e1_imm;
            r_e0_tag <= r_e1_tag;
            r_e0_err <= r_e1_err;
         end
         if (w_ld_e1_in) begin
            r_e1_imm <= w_imm;
            r_e1_tag <= s.TagD;
            r_e1_err <= w_err;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_skid.sv
// tb/tb_imm_gen_skid.sv - Self-checking bench for imm_gen_skid at XLEN 32 and 64
module tb_imm_gen_skid;
    localparam int TAG_W = 8;

    typedef struct packed {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    ent_t q32[$];
    ent_t q64[$];

    always #5 clk = ~clk;

    imm_gen_skid_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_skid_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    imm_gen_skid #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .reset(reset), .flush(flush), .s(bus32));
    imm_gen_skid #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk(clk), .reset(reset), .flush(flush), .s(bus64));

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt, input int xlen);
        longint s;
        longint t;
        s = longint'($signed(ins));
        case (fmt)
            3'd0: t = s >>> 20;
            3'd1: begin
                t = s >>> 25;
                t = t * 32 + longint'((ins >> 7) & 32'd31);
            end
            3'd2: begin
                t = s >>> 31;
                t = t * 4096 + longint'((ins >> 7) & 32'd1) * 2048
                    + longint'((ins >> 25) & 32'd63) * 32 + longint'((ins >> 8) & 32'd15) * 2;
            end
            3'd3: begin
                t = s >>> 31;
                t = t * 1048576 + longint'((ins >> 12) & 32'd255) * 4096
                    + longint'((ins >> 20) & 32'd1) * 2048 + longint'((ins >> 21) & 32'd1023) * 2;
            end
            3'd4: begin
                t = s >>> 12;
                t = t * 4096;
            end
            3'd5: t = longint'((ins >> 15) & 32'd31);
            3'd6: t = longint'((ins >> 20) & ((xlen == 32) ? 32'd31 : 32'd63));
            default: t = 0;
        endcase
        if (xlen == 32) return t & 64'hFFFF_FFFF;
        return t;
    endfunction

    task automatic drv32(input logic v, input logic [31:0] ins, input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        bus32.in_valid = v;  bus32.InstrD = ins[31:7];  bus32.ImmFormatD = fmt;  bus32.TagD = tag;
    endtask

    task automatic drv64(input logic v, input logic [31:0] ins, input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        bus64.in_valid = v;  bus64.InstrD = ins[31:7];  bus64.ImmFormatD = fmt;  bus64.TagD = tag;
    endtask

    task automatic tick();
        ent_t e;
        bit   p;
        bit   o;
        @(negedge clk);
        if (reset || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            p = bus32.in_valid && (q32.size() < 2);
            o = bus32.out_ready && (q32.size() > 0);
            e.imm = ref_imm({bus32.InstrD, 7'b0}, bus32.ImmFormatD, 32);
            e.tag = bus32.TagD;
            e.err = (bus32.ImmFormatD == 3'd7);
            if (o) void'(q32.pop_front());
            if (p) q32.push_back(e);
            p = bus64.in_valid && (q64.size() < 2);
            o = bus64.out_ready && (q64.size() > 0);
            e.imm = ref_imm({bus64.InstrD, 7'b0}, bus64.ImmFormatD, 64);
            e.tag = bus64.TagD;
            e.err = (bus64.ImmFormatD == 3'd7);
            if (o) void'(q64.pop_front());
            if (p) q64.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus32.out_valid, bus32.in_ready, bus32.fmt_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags32 got valid/ready/err=%b expected 000", {bus32.out_valid, bus32.in_ready, bus32.fmt_err});
        end
        checks++;
        if (bus32.ExtImmE !== 32'd0 || bus32.TagE !== '0) begin
            errors++;
            $display("FAIL reset_data32 got imm=%h tag=%h expected 0/0", bus32.ExtImmE, bus32.TagE);
        end
        checks++;
        if (bus64.ExtImmE !== 64'd0 || bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state64 got imm=%h valid=%b ready=%b expected 0/0/0", bus64.ExtImmE, bus64.out_valid, bus64.in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 1", bus32.in_ready);
        end
    endtask

    task automatic test_format_sweep();
        logic [31:0] ins_t [6];
        logic [31:0] exp_t [6];
        ins_t = '{32'hFFF00093, 32'hFE000C23, 32'h00000463, 32'hFFDFF06F, 32'h123450B7, 32'h000F8073};
        exp_t = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F};
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drv32(1'b1, ins_t[k], 3'(k), TAG_W'(k + 1));
            tick();
            checks++;
            if (bus32.out_valid !== 1'b1 || bus32.ExtImmE !== exp_t[k] || bus32.TagE !== TAG_W'(k + 1) || bus32.fmt_err !== 1'b0) begin
                errors++;
                $display("FAIL sweep_fmt%0d got valid=%b imm=%h tag=%0d err=%b expected 1 %h %0d 0",
                         k, bus32.out_valid, bus32.ExtImmE, bus32.TagE, bus32.fmt_err, exp_t[k], k + 1);
            end
        end
        drv32(1'b0, 32'd0, 3'd0, '0);
        tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain got valid=%b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus32.out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            drv32(1'b1, (32'(t) << 20) | 32'h93, 3'd0, TAG_W'(t));
            tick();
            checks++;
            if (bus32.in_ready !== (t == 1) || bus32.TagE !== TAG_W'(1) || bus32.ExtImmE !== 32'd1) begin
                errors++;
                $display("FAIL bp_push%0d got ready=%b tag=%0d imm=%h expected %b 1 00000001", t, bus32.in_ready, bus32.TagE, bus32.ExtImmE, t == 1);
            end
        end
        repeat (3) tick();
        checks++;
        if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.TagE !== TAG_W'(1)) begin
            errors++;
            $display("FAIL bp_hold got ready=%b valid=%b tag=%0d expected 0 1 1", bus32.in_ready, bus32.out_valid, bus32.TagE);
        end
        bus32.out_ready = 1'b1;
        tick();
        checks++;
        if (bus32.TagE !== TAG_W'(2) || bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1 got tag=%0d valid=%b ready=%b expected 2 1 1", bus32.TagE, bus32.out_valid, bus32.in_ready);
        end
        tick();
        drv32(1'b0, 32'd0, 3'd0, '0);
        checks++;
        if (bus32.TagE !== TAG_W'(3) || bus32.ExtImmE !== 32'd3 || bus32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reoffer got tag=%0d imm=%h valid=%b expected 3 00000003 1", bus32.TagE, bus32.ExtImmE, bus32.out_valid);
        end
        tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got valid=%b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drv32(1'b1, $urandom(), 3'($urandom_range(0, 6)), TAG_W'(8'h40 + k));
            tick();
            checks++;
            if (q32.size() != 1 || bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b1 || bus32.TagE !== TAG_W'(8'h40 + k)
                || bus32.ExtImmE !== q32[0].imm[31:0]) begin
                errors++;
                $display("FAIL b2b_word%0d got valid=%b ready=%b tag=%h imm=%h expected 1 1 %h %h", k, bus32.out_valid,
                         bus32.in_ready, bus32.TagE, bus32.ExtImmE, TAG_W'(8'h40 + k), (q32.size() == 1) ? q32[0].imm[31:0] : 32'hX);
            end
        end
        drv32(1'b0, 32'd0, 3'd0, '0);
        tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got valid=%b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        drv32(1'b1, 32'h00500093, 3'd0, 8'hA1);
        tick();
        drv32(1'b1, 32'h00600093, 3'd0, 8'hA2);
        tick();
        flush = 1'b1;
        drv32(1'b1, 32'hFFF00093, 3'd0, 8'hEE);
        #1;
        checks++;
        if (bus32.in_ready !== 1'b0 || bus32.TagE !== 8'hA1) begin
            errors++;
            $display("FAIL flush_full_pre got ready=%b tag=%h expected 0 a1", bus32.in_ready, bus32.TagE);
        end
        tick();
        flush = 1'b0;
        drv32(1'b0, 32'd0, 3'd0, '0);
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full_post got valid=%b ready=%b expected 0 1", bus32.out_valid, bus32.in_ready);
        end
        bus32.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost got valid=%b expected 0", bus32.out_valid);
        end
        bus32.out_ready = 1'b0;
        drv32(1'b1, 32'h00700093, 3'd0, 8'hB1);
        tick();
        flush = 1'b1;
        drv32(1'b1, 32'h00800093, 3'd0, 8'hB2);
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_one_pre got ready=%b expected 1", bus32.in_ready);
        end
        tick();
        flush = 1'b0;
        drv32(1'b0, 32'd0, 3'd0, '0);
        tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_one_post got valid=%b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_async_reset();
        bus32.out_ready = 1'b0;
        bus64.out_ready = 1'b0;
        drv32(1'b1, 32'hFFF00093, 3'd0, 8'h5A);
        drv64(1'b1, 32'h12345678, 3'd7, 8'h5C);
        tick();
        drv32(1'b1, 32'h123450B7, 3'd4, 8'h5B);
        drv64(1'b0, 32'd0, 3'd0, '0);
        tick();
        drv32(1'b0, 32'd0, 3'd0, '0);
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.ExtImmE !== 32'hFFFFFFFF || bus64.fmt_err !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got valid=%b imm=%h err64=%b expected 1 ffffffff 1", bus32.out_valid, bus32.ExtImmE, bus64.fmt_err);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus32.out_valid, bus32.in_ready, bus32.fmt_err} !== 3'b000 || bus32.ExtImmE !== 32'd0 || bus32.TagE !== '0) begin
            errors++;
            $display("FAIL areset_mid32 got valid/ready/err=%b imm=%h tag=%h expected 000 0 0",
                     {bus32.out_valid, bus32.in_ready, bus32.fmt_err}, bus32.ExtImmE, bus32.TagE);
        end
        checks++;
        if (bus64.fmt_err !== 1'b0 || bus64.out_valid !== 1'b0 || bus64.TagE !== '0) begin
            errors++;
            $display("FAIL areset_mid64 got err=%b valid=%b tag=%h expected 0 0 0", bus64.fmt_err, bus64.out_valid, bus64.TagE);
        end
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus32.out_ready = 1'b1;
        drv32(1'b1, 32'hFE000C23, 3'd1, 8'h77);
        tick();
        drv32(1'b0, 32'd0, 3'd0, '0);
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.ExtImmE !== 32'hFFFFFFF8 || bus32.TagE !== 8'h77) begin
            errors++;
            $display("FAIL areset_first got valid=%b imm=%h tag=%h expected 1 fffffff8 77", bus32.out_valid, bus32.ExtImmE, bus32.TagE);
        end
        tick();
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_drain got valid=%b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] ins_t [4];
        logic [2:0]  fmt_t [4];
        logic [63:0] exp_t [4];
        ins_t = '{32'h800000B7, 32'h03F01013, $urandom(), 32'hFFF00093};
        fmt_t = '{3'd4, 3'd6, 3'd7, 3'd0};
        exp_t = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'd0, 64'hFFFFFFFFFFFFFFFF};
        bus64.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv64(1'b1, ins_t[k], fmt_t[k], TAG_W'(8'hC0 + k));
            tick();
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.ExtImmE !== exp_t[k] || bus64.fmt_err !== (k == 2) || bus64.TagE !== TAG_W'(8'hC0 + k)) begin
                errors++;
                $display("FAIL x64_entry%0d got valid=%b imm=%h err=%b tag=%h expected 1 %h %b %h",
                         k, bus64.out_valid, bus64.ExtImmE, bus64.fmt_err, bus64.TagE, exp_t[k], k == 2, TAG_W'(8'hC0 + k));
            end
        end
        drv64(1'b0, 32'd0, 3'd0, '0);
        tick();
        checks++;
        if (bus64.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL x64_drain got valid=%b expected 0", bus64.out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drv32($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)), TAG_W'($urandom()));
            drv64($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)), TAG_W'($urandom()));
            bus32.out_ready = ($urandom_range(0, 2) != 0);
            bus64.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (bus32.out_valid !== (q32.size() != 0) || bus32.in_ready !== (q32.size() < 2)) begin
                errors++;
                $display("FAIL rand32_ctl c=%0d got valid=%b ready=%b expected %b %b", c, bus32.out_valid, bus32.in_ready, q32.size() != 0, q32.size() < 2);
            end
            if (q32.size() != 0) begin
                checks++;
                if (bus32.ExtImmE !== q32[0].imm[31:0] || bus32.TagE !== q32[0].tag || bus32.fmt_err !== q32[0].err) begin
                    errors++;
                    $display("FAIL rand32_head c=%0d got imm=%h tag=%h err=%b expected %h %h %b", c, bus32.ExtImmE, bus32.TagE,
                             bus32.fmt_err, q32[0].imm[31:0], q32[0].tag, q32[0].err);
                end
            end
            checks++;
            if (bus64.out_valid !== (q64.size() != 0) || bus64.in_ready !== (q64.size() < 2)) begin
                errors++;
                $display("FAIL rand64_ctl c=%0d got valid=%b ready=%b expected %b %b", c, bus64.out_valid, bus64.in_ready, q64.size() != 0, q64.size() < 2);
            end
            if (q64.size() != 0) begin
                checks++;
                if (bus64.ExtImmE !== q64[0].imm || bus64.TagE !== q64[0].tag || bus64.fmt_err !== q64[0].err) begin
                    errors++;
                    $display("FAIL rand64_head c=%0d got imm=%h tag=%h err=%b expected %h %h %b", c, bus64.ExtImmE, bus64.TagE,
                             bus64.fmt_err, q64[0].imm, q64[0].tag, q64[0].err);
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        drv32(1'b0, 32'd0, 3'd0, '0);
        drv64(1'b0, 32'd0, 3'd0, '0);
        bus32.out_ready = 1'b0;
        bus64.out_ready = 1'b0;
        test_reset();
        test_format_sweep();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_xlen64();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within 500000 time units");
        $fatal(1);
    end
endmodule
